// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: state encoding, baud divisor helper, default line rate.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_pkg;

  localparam int DEFAULT_BAUD = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // Whole clock cycles per bit; the remainder is dropped.
  function automatic int clks_per_bit(input int clk_freq_hz, input int baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_tick marks the last cycle of each bit.
// restart realigns the count so the first bit starts the cycle after an accept.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and a registered txd pin.
// Define UART_TX_PARITY_EN to append an even-parity bit after data bit 7.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUD_RATE   = DEFAULT_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       txd
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $fatal(1, "uart_tx: CLKS_PER_BIT must be >= 2");
  end

  state_t     state, state_n;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       txd_n;
  logic       restart;
  logic       bit_tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_bit <= 1'b0;
    end else if (restart) begin
      parity_bit <= ^tx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_cnt_n;
      txd     <= txd_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    txd_n     = txd;
    restart   = 1'b0;
    tx_done   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (tx_valid) begin
          state_n   = ST_START;
          shift_n   = tx_data;
          bit_cnt_n = '0;
          txd_n     = 1'b0;
          restart   = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_n = ST_DATA;
          txd_n   = shift[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_n   = {1'b0, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = ST_PARITY;
            txd_n   = parity_bit;
`else
            state_n = ST_STOP;
            txd_n   = 1'b1;
`endif
          end else begin
            txd_n = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          state_n = ST_STOP;
          txd_n   = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          state_n = ST_IDLE;
          tx_done = 1'b1;
          txd_n   = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

  assign tx_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at D = 10 clocks per bit; expected line
// waveforms come from a frame-bit queue built from the byte value.
module tb_uart_tx;

  localparam int D = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * D;

  localparam int M_IDLE  = 0;
  localparam int M_HOLD  = 1;
  localparam int M_PULSE = 2;
  localparam int M_RESET = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       txd;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  uart_tx #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .txd      (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge: returns the cycle in which the offered byte is accepted.
  task automatic wait_accept(output int t);
    t = -1;
    for (int n = 0; n < 2000; n++) begin
      if (tx_ready === 1'b1) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
    compared++;
    mismatched++;
    $display("FAIL accept_timeout: tx_ready stayed %b, required 1 within 2000 cycles", tx_ready);
  endtask

  // Observes cycles T+1 .. T+FRAME+1 after an accept in cycle T.
  task automatic watch_frame(input logic [7:0] b, input int mode, input logic [7:0] nb,
                             input string tag);
    logic       bits[$];
    logic [2:0] exp;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        if (mode == M_HOLD) begin
          tx_data = nb;
        end else begin
          tx_valid = 1'b0;
          tx_data  = 8'($urandom);
        end
      end
      if (mode == M_PULSE && k == 40) begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
      end
      if (mode == M_PULSE && k == 41) tx_valid = 1'b0;
      if (mode == M_RESET && k == 45) rst = 1'b1;
      @(negedge clk);
      if (mode == M_RESET && k == 45) begin
        compared++;
        if ({txd, tx_ready, tx_done} !== 3'b110) begin
          mismatched++;
          $display("FAIL %s_reset_now: txd/ready/done=%b required 110", tag, {txd, tx_ready, tx_done});
        end
        return;
      end
      exp = (k <= FRAME) ? {bits[(k - 1) / D], 1'b0, (k == FRAME)} : 3'b110;
      compared++;
      if ({txd, tx_ready, tx_done} !== exp) begin
        mismatched++;
        $display("FAIL %s_T+%0d: txd/ready/done=%b required %b", tag, k, {txd, tx_ready, tx_done}, exp);
      end
    end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compared++;
      if ({txd, tx_ready, tx_done} !== 3'b110) begin
        mismatched++;
        $display("FAIL %s_idle%0d: txd/ready/done=%b required 110", tag, i, {txd, tx_ready, tx_done});
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int mode, input string tag);
    int t;
    tx_data  = b;
    tx_valid = 1'b1;
    wait_accept(t);
    watch_frame(b, mode, 8'h00, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle_check(50, "reset");
  endtask

  task automatic test_frame();
    send(8'h55, M_IDLE, "f55");
    idle_check(5, "f55_after");
  endtask

  task automatic test_back_to_back();
    int t1, t2;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_accept(t1);
    watch_frame(8'h00, M_HOLD, 8'hFF, "b2b_00");
    wait_accept(t2);
    compared++;
    if (t2 - t1 !== FRAME + 1) begin
      mismatched++;
      $display("FAIL b2b_gap: second accept %0d cycles after first, required %0d", t2 - t1, FRAME + 1);
    end
    watch_frame(8'hFF, M_IDLE, 8'h00, "b2b_ff");
    idle_check(5, "b2b_after");
  endtask

  task automatic test_busy_ignore();
    send(8'h81, M_PULSE, "busy81");
    idle_check(3 * FRAME / 2, "busy_after");
  endtask

  task automatic test_reset_mid_frame();
    send(8'hC3, M_RESET, "rstC3");
    @(posedge clk);
    #1 rst = 1'b0;
    idle_check(20, "rst_release");
    send(8'h3C, M_IDLE, "f3C");
    idle_check(5, "f3C_after");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send(8'h07, M_IDLE, "par07");
    send(8'h03, M_IDLE, "par03");
    idle_check(5, "par_after");
  endtask
`endif

  task automatic test_random();
    logic [7:0] b, nb;
    int         t, prev_t;
    bit         held;
    held   = 1'b0;
    prev_t = 0;
    b      = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (!held) begin
        tx_data  = b;
        tx_valid = 1'b1;
      end
      wait_accept(t);
      if (held) begin
        compared++;
        if (t - prev_t !== FRAME + 1) begin
          mismatched++;
          $display("FAIL rnd%0d_gap: accept after %0d cycles, required %0d", i, t - prev_t, FRAME + 1);
        end
      end
      held = 1'($urandom_range(0, 1));
      nb   = 8'($urandom);
      watch_frame(b, held ? M_HOLD : M_IDLE, nb, $sformatf("rnd%0d_%02h", i, b));
      prev_t = t;
      b      = nb;
      if (!held) repeat ($urandom_range(0, 7)) @(negedge clk);
    end
    if (held) tx_valid = 1'b0;
    idle_check(FRAME + 5, "rnd_after");
  endtask

  initial begin
    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    test_reset();
    test_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
